gpio_arbiter: RTL

GPIO_ARBITER -- requirements
Module: gpio_arbiter

---
 rtl/gpio_arb_pkg.sv | 23 ++
 rtl/gpio_arb_pick.sv | 23 ++
 rtl/gpio_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/gpio_arb_pkg.sv
// rtl/gpio_arb_pkg.sv - shared types and defaults for the two-master GPIO arbiter
package gpio_arb_pkg;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 2;

  // Transaction sequencer: sample/latch, drive the GPIO port, report completion
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } mid_t;

  function automatic mid_t other_master(input mid_t m);
    return (m == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/gpio_arb_pick.sv
// rtl/gpio_arb_pick.sv - combinational winner selection between two requesters
module gpio_arb_pick
  import gpio_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  mid_t last,
  output mid_t winner,
  output logic valid
);

  // A lone requester wins outright; on a tie the master not served last wins
  always_comb begin
    valid  = req0 | req1;
    winner = M0;
    if (req0 && req1) begin
      winner = other_master(last);
    end else if (req1) begin
      winner = M1;
    end
  end

endmodule

// File: rtl/gpio_arbiter.sv
// rtl/gpio_arbiter.sv - two-master GPIO access arbiter, GPIO_ARB_RR_EN selects round-robin ties
module gpio_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] a0,
  input  logic [AW-1:0] a1,
  input  logic          we0,
  input  logic          we1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1,
  output logic [AW-1:0] A,
  output logic          WE,
  output logic [DW-1:0] WD,
  input  logic [DW-1:0] RD
);

  state_t        state;
  state_t        state_nxt;
  mid_t          id_q;
  logic [AW-1:0] a_q;
  logic          we_q;
  logic [DW-1:0] wd_q;
  mid_t          pick_id;
  logic          pick_vld;
  mid_t          last;
  logic          take;

  // A new access is accepted only from IDLE; everything latched here is frozen until it completes
  assign take = (state == ST_IDLE) && pick_vld;

`ifdef GPIO_ARB_RR_EN
  mid_t last_q;

  // Remember who was granted most recently so the next tie goes to the other master
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= M1;
    end else if (take) begin
      last_q <= pick_id;
    end
  end

  assign last = last_q;
`else
  // Treating master 1 as always "last served" turns the picker into fixed priority for master 0
  assign last = M1;
`endif

  gpio_arb_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last),
    .winner (pick_id),
    .valid  (pick_vld)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the winner's id and request fields when the access is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q <= M0;
      a_q  <= '0;
      we_q <= 1'b0;
      wd_q <= '0;
    end else if (take) begin
      id_q <= pick_id;
      a_q  <= (pick_id == M1) ? a1  : a0;
      we_q <= (pick_id == M1) ? we1 : we0;
      wd_q <= (pick_id == M1) ? wd1 : wd0;
    end
  end

  // Read data is sampled at the end of the ACCESS cycle; writes leave it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      rd0 <= '0;
      rd1 <= '0;
    end else if (state == ST_ACCESS && !we_q) begin
      if (id_q == M1) begin
        rd1 <= RD;
      end else begin
        rd0 <= RD;
      end
    end
  end

  // Next state and port outputs; the GPIO port is driven only during ACCESS
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    A         = '0;
    WE        = 1'b0;
    WD        = '0;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_nxt = ST_RESP;
        gnt0      = (id_q == M0);
        gnt1      = (id_q == M1);
        A         = a_q;
        WE        = we_q;
        WD        = wd_q;
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
        gnt0      = (id_q == M0);
        gnt1      = (id_q == M1);
        done0     = (id_q == M0);
        done1     = (id_q == M1);
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
